// File: rtl/rv_fetch_aligner_if.sv
// Handshake bundle between the fetch aligner, instruction memory, execute-stage
// redirect and the decoder.
interface rv_fetch_aligner_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [63:0] out_pc;
  logic        out_is_compressed;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_insn, out_pc, out_is_compressed,
    input  out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_insn, out_pc, out_is_compressed,
    output out_ready
  );
endinterface

// File: rtl/rv_fetch_aligner.sv
// Fetch aligner: word-aligned fetches into a 3-halfword buffer, emits one
// 16/32-bit instruction per handshake with its PC; handles redirects and stale fetches.
module rv_fetch_aligner #(
  parameter logic [63:0] reset_pc = 64'h0
) (
  input  logic             clock,
  input  logic             reset,
  rv_fetch_aligner_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t            state_q;
  logic [2:0][15:0]  buf_q, buf_n, surv;
  logic [1:0]        count_q, count_n, surv_cnt, push_cnt;
  logic [63:0]       out_pc_q, fetch_addr_q;
  logic              drop_half_q, live_q;
  logic              is_comp, req_fire, out_fire, resp_take;
  logic [15:0]       h0, h1;

  assign is_comp               = buf_q[0][1:0] != 2'b11;
  assign bus.out_valid         = is_comp ? (count_q >= 2'd1) : (count_q >= 2'd2);
  assign bus.out_insn          = is_comp ? {16'h0, buf_q[0]} : {buf_q[1], buf_q[0]};
  assign bus.out_pc            = out_pc_q;
  assign bus.out_is_compressed = is_comp;
  // live_q keeps the request low for the first cycle after reset releases
  assign bus.mem_req_valid     = live_q && (state_q == IDLE) && (count_q <= 2'd1);
  assign bus.mem_req_addr      = fetch_addr_q;

  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign resp_take = (state_q == WAIT) && bus.mem_resp_valid;
  assign h0        = drop_half_q ? bus.mem_resp_data[31:16] : bus.mem_resp_data[15:0];
  assign h1        = bus.mem_resp_data[31:16];

  always_comb begin
    surv     = buf_q;
    surv_cnt = count_q;
    if (out_fire) begin
      if (is_comp) begin
        surv[0]  = buf_q[1];
        surv[1]  = buf_q[2];
        surv_cnt = count_q - 2'd1;
      end else begin
        surv[0]  = buf_q[2];
        surv_cnt = count_q - 2'd2;
      end
    end
    push_cnt = !resp_take ? 2'd0 : (drop_half_q ? 2'd1 : 2'd2);
    // pushed halfwords land after the survivors; slots past count are don't-care
    buf_n = surv;
    if (resp_take) begin
      case (surv_cnt)
        2'd0: begin buf_n[0] = h0; buf_n[1] = h1; end
        2'd1: begin buf_n[1] = h0; buf_n[2] = h1; end
        2'd2: buf_n[2] = h0;
        default: ;
      endcase
    end
    count_n = surv_cnt + push_cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 2'd0;
      buf_q        <= '0;
      out_pc_q     <= reset_pc & ~64'h1;
      fetch_addr_q <= reset_pc & ~64'h3;
      drop_half_q  <= reset_pc[1];
      live_q       <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (bus.redirect_valid) begin
        count_q      <= 2'd0;
        out_pc_q     <= bus.redirect_pc & ~64'h1;
        fetch_addr_q <= bus.redirect_pc & ~64'h3;
        drop_half_q  <= bus.redirect_pc[1];
        // any fetch still owed to us is stale and must be swallowed
        case (state_q)
          IDLE:    state_q <= req_fire ? DISCARD : IDLE;
          default: state_q <= bus.mem_resp_valid ? IDLE : DISCARD;
        endcase
      end else begin
        count_q <= count_n;
        buf_q   <= buf_n;
        if (out_fire) out_pc_q <= out_pc_q + (is_comp ? 64'd2 : 64'd4);
        case (state_q)
          IDLE: if (req_fire) begin
            fetch_addr_q <= fetch_addr_q + 64'd4;
            state_q      <= WAIT;
          end
          WAIT: if (bus.mem_resp_valid) begin
            state_q     <= IDLE;
            drop_half_q <= 1'b0;
          end
          DISCARD: if (bus.mem_resp_valid) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Bench for rv_fetch_aligner: memory model with configurable latency, scoreboard
// of expected instructions, vector table plus redirect/stall sequences.
module tb_rv_fetch_aligner;
  logic clock, reset;
  rv_fetch_aligner_if bus();

  rv_fetch_aligner #(.reset_pc(64'h1000)) dut (
    .clock(clock), .reset(reset), .bus(bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] insn;
    logic [63:0] pc;
    logic        comp;
  } exp_t;

  typedef struct {
    logic [63:0]      pc;
    logic [31:0]      w0;
    logic [31:0]      w1;
    int               n;
    logic [2:0][31:0] insn;
    logic [2:0][63:0] ipc;
    logic [2:0]       comp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vq[$];
  logic [63:0] req_log[$];
  logic [31:0] mem [logic [63:0]];
  int          total = 0, passed = 0;
  int          pend_cnt = 0, lat = 1;
  logic [63:0] pend_addr = '0;
  logic        ready_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic bit seen(input logic [63:0] a);
    foreach (req_log[i]) if (req_log[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 64'hdead_dead_dead_dead;
  endfunction

  // Everything for one cycle happens at its negedge: decoder, memory, request capture.
  task automatic step();
    exp_t e;
    @(negedge clock);
    bus.redirect_valid = 1'b0;
    bus.out_ready = ready_en && (sb.size() > 0);
    if (bus.out_valid && bus.out_ready) begin
      e = sb.pop_front();
      chk($sformatf("insn@%h", e.pc), {32'h0, bus.out_insn}, {32'h0, e.insn});
      chk($sformatf("pc@%h", e.pc), bus.out_pc, e.pc);
      chk($sformatf("comp@%h", e.pc), {63'h0, bus.out_is_compressed}, {63'h0, e.comp});
    end
    bus.mem_resp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = rd(pend_addr);
      end
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      chk("single_outstanding", 64'(pend_cnt), 64'd0);
      pend_cnt  = lat;
      pend_addr = bus.mem_req_addr;
      req_log.push_back(bus.mem_req_addr);
    end
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    req_log.delete();
    step();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin step(); n++; end
    chk({"drain_", tag}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic expect_insn(input logic [31:0] insn, input logic [63:0] pc, input logic comp);
    exp_t e;
    e.insn = insn; e.pc = pc; e.comp = comp;
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic [63:0] pc, input logic [31:0] w0, input logic [31:0] w1,
                              input int n, input logic [31:0] i0, input logic [63:0] p0,
                              input logic [31:0] i1, input logic [63:0] p1,
                              input logic [31:0] i2, input logic [63:0] p2, input logic [2:0] comp);
    vec_t v;
    v.pc = pc; v.w0 = w0; v.w1 = w1; v.n = n; v.comp = comp;
    v.insn[0] = i0; v.insn[1] = i1; v.insn[2] = i2;
    v.ipc[0]  = p0; v.ipc[1]  = p1; v.ipc[2]  = p2;
    return v;
  endfunction

  initial begin
    int n, changes;
    vec_t v;
    logic [63:0] wa;

    vq.push_back(mk(64'h1000, 32'h0000_0013, 32'h0, 1,
                    32'h0000_0013, 64'h1000, 32'h0, 64'h0, 32'h0, 64'h0, 3'b000));
    vq.push_back(mk(64'h1000, 32'h4081_4501, 32'h0, 2,
                    32'h0000_4501, 64'h1000, 32'h0000_4081, 64'h1002, 32'h0, 64'h0, 3'b011));
    vq.push_back(mk(64'h1000, 32'h0013_4505, 32'h4501_0000, 3,
                    32'h0000_4505, 64'h1000, 32'h0000_0013, 64'h1002, 32'h0000_4501, 64'h1006, 3'b101));
    vq.push_back(mk(64'h2002, 32'h1234_5678, 32'h0, 1,
                    32'h0000_1234, 64'h2002, 32'h0, 64'h0, 32'h0, 64'h0, 3'b001));
    vq.push_back(mk(64'h3002, 32'h1117_0000, 32'h0001_0000, 2,
                    32'h0000_1117, 64'h3002, 32'h0000_0001, 64'h3006, 32'h0, 64'h0, 3'b010));
    vq.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 32'h4081_4501, 32'h0, 3,
                    32'h0000_4501, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_4081, 64'hFFFF_FFFF_FFFF_FFFE,
                    32'h0000_0000, 64'h0, 3'b111));

    reset = 1'b1;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    mem[64'h1000] = 32'h0000_0013;
    repeat (3) step();
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'd0);
    chk("rst_req_valid", {63'h0, bus.mem_req_valid}, 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'h1000);
    chk("rst_req_addr", bus.mem_req_addr, 64'h1000);

    reset = 1'b0;
    expect_insn(32'h0000_0013, 64'h1000, 1'b0);
    step();
    chk("first_req_valid", {63'h0, bus.mem_req_valid}, 64'd1);
    chk("first_req_addr", bus.mem_req_addr, 64'h1000);
    drain("reset", 50);
    repeat (4) step();
    chk("next_req_addr", req_at(1), 64'h1004);

    foreach (vq[k]) begin
      v  = vq[k];
      wa = v.pc & ~64'h3;
      mem[wa] = v.w0;
      mem[wa + 64'd4] = v.w1;
      redirect(v.pc);
      for (int i = 0; i < v.n; i++) expect_insn(v.insn[i], v.ipc[i], v.comp[i]);
      drain($sformatf("vec%0d", k), 100);
      chk($sformatf("vec%0d_first_req", k), req_at(0), wa);
    end

    // Redirect while a slow fetch is outstanding: its data must never surface.
    lat = 2;
    mem[64'h1000] = 32'h0000_0013;
    mem[64'h1004] = 32'h0000_4501;
    mem[64'h2000] = 32'h1234_5678;
    redirect(64'h1000);
    expect_insn(32'h0000_0013, 64'h1000, 1'b0);
    n = 0;
    while (!seen(64'h1004) && n < 50) begin step(); n++; end
    chk("wait_fetch_1004", {63'h0, seen(64'h1004)}, 64'd1);
    step();
    redirect(64'h2002);
    expect_insn(32'h0000_1234, 64'h2002, 1'b1);
    drain("redir_wait", 100);
    chk("redir_wait_req", req_at(0), 64'h2000);

    // Redirect in the very cycle the response lands.
    lat = 1;
    mem[64'h4000] = 32'h4501_4501;
    mem[64'h5000] = 32'h0000_0001;
    redirect(64'h4000);
    n = 0;
    while (!seen(64'h4000) && n < 50) begin step(); n++; end
    step();
    chk("resp_cycle_present", {63'h0, bus.mem_resp_valid}, 64'd1);
    redirect(64'h5000);
    chk("resp_redir_no_valid", {63'h0, bus.out_valid}, 64'd0);
    chk("resp_redir_req_valid", {63'h0, bus.mem_req_valid}, 64'd1);
    chk("resp_redir_req_addr", bus.mem_req_addr, 64'h5000);
    expect_insn(32'h0000_0001, 64'h5000, 1'b1);
    drain("redir_resp", 100);

    // Decoder stall: buffer fills, fetching stops, head stays put, then drains in order.
    mem[64'h6000] = 32'h4081_4501;
    mem[64'h6004] = 32'h0000_0013;
    mem[64'h6008] = 32'h4501_4505;
    ready_en = 1'b0;
    redirect(64'h6000);
    expect_insn(32'h0000_4501, 64'h6000, 1'b1);
    expect_insn(32'h0000_4081, 64'h6002, 1'b1);
    expect_insn(32'h0000_0013, 64'h6004, 1'b0);
    expect_insn(32'h0000_4505, 64'h6008, 1'b1);
    expect_insn(32'h0000_4501, 64'h600A, 1'b1);
    changes = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i >= 3 && (!bus.out_valid || bus.out_insn != 32'h0000_4501 || bus.out_pc != 64'h6000))
        changes++;
    end
    chk("stall_head_stable", 64'(changes), 64'd0);
    chk("stall_one_fetch", 64'(req_log.size()), 64'd1);
    ready_en = 1'b1;
    drain("stall_release", 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rv_fetch_aligner.md
# rv_fetch_aligner

Fetch-side aligner that keeps the decompressing decoder supplied with instructions. It issues word-aligned 32-bit fetches to instruction memory and buffers the returned halfwords. Each cycle it presents one complete instruction (16-bit compressed, or 32-bit possibly straddling a word boundary) with its PC on a valid/ready output. It also handles PC redirects from the execute stage, including discarding in-flight stale fetches.

## Interface

- `reset_pc`, default `64'h0`: PC loaded on reset; bit 0 must be 0.

- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `mem_req_valid`  out  1  fetch request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  64  fetch address, bits [1:0] always 0
- `mem_resp_valid`  in  1  fetch data returned (in order, ≥1 cycle after acceptance)
- `mem_resp_data`  in  32  fetched word, little-endian halfwords
- `redirect_valid`  in  1  flush and restart at `redirect_pc`
- `redirect_pc`  in  64  new PC, bit 0 must be 0
- `out_valid`  out  1  instruction available to decoder
- `out_ready`  in  1  decoder consumes instruction
- `out_insn`  out  32  instruction; compressed ones zero-extended to 32 bits
- `out_pc`  out  64  PC of `out_insn`
- `out_is_compressed`  out  1  `out_insn[1:0] != 2'b11`

## Operation

- Halfword buffer: 3 entries × 16 bits, `count` 0..3; entry 0 is at `out_pc`.
- Instruction ready:
  - `count ≥ 1` and entry0[1:0] ≠ 11 → compressed; `out_insn = {16'h0, entry0}`.
  - `count ≥ 2` and entry0[1:0] = 11 → `out_insn = {entry1, entry0}`.
  - `out_valid` is set when either holds.
- Pop on `out_valid & out_ready`: remove 1 or 2 entries; `out_pc += 2` or `+4` (64-bit wrap).
- Fetch FSM states:
  - IDLE: `mem_req_valid = (count ≤ 1)`. On `mem_req_valid & mem_req_ready`: `fetch_addr += 4`, go to WAIT.
  - WAIT: on `mem_resp_valid`, push halfwords and go to IDLE. If `drop_half` is set, push only `data[31:16]` and clear `drop_half`; otherwise push `data[15:0]` then `data[31:16]`.
  - DISCARD: on `mem_resp_valid`, drop the data and go to IDLE.
- `mem_resp_valid` in IDLE is ignored. At most one request is outstanding.
- Same-cycle pop and push: `count_next = count − pop + push`. Pushed halfwords land after the surviving entries. The `count ≤ 1` fetch rule guarantees this never exceeds 3.
- Redirect (`redirect_valid`) has priority over all other updates:
  - `count ← 0`, `out_pc ← redirect_pc`, `fetch_addr ← redirect_pc & ~3`, `drop_half ← redirect_pc[1]`.
  - FSM: WAIT without a response this cycle → DISCARD. WAIT with a response this cycle → IDLE, response dropped. DISCARD stays DISCARD unless a response arrives this cycle, then → IDLE. IDLE → IDLE.
  - A request handshake in the redirect cycle is treated as issued: its response is discarded (FSM → DISCARD).
  - An output handshake in the redirect cycle completes normally for the consumer; the buffer is flushed regardless.
- Reset: behaves as a redirect to `reset_pc` with FSM forced to IDLE. Memory shares this reset, so no pre-reset response arrives afterwards.
- Misaligned `redirect_pc[0] = 1` is outside contract; bit 0 is ignored.

## Timing

- Reset values: `mem_req_valid = 0`, `out_valid = 0`, `out_pc = reset_pc`, `count = 0`, FSM = IDLE, `mem_req_addr = reset_pc & ~3`.
- All outputs are combinational from registers only; there is no input-to-output path.
- Cycle after reset deassert or after redirect: `mem_req_valid = 1` with the new word address (unless the FSM is in DISCARD).
- Response in cycle t → `out_valid` in t+1 if the pushed halfwords complete an instruction.
- Best case, redirect at t, `mem_req_ready` high, 1-cycle memory:
  - request at t+1
  - response at t+2
  - `out_valid` at t+3
- Straddling 32-bit instruction: `out_valid` only after the second word's response.
- Sustained throughput with 1-cycle memory: one 32-bit instruction per 2 cycles minimum; compressed pairs at one per cycle.
- `out_valid`, `out_insn`, `out_pc` hold stable while `out_ready = 0`.

## Test plan

- Reset with `reset_pc = 0x1000` → `mem_req_addr = 0x1000` one cycle after deassert. Respond `0x00000013` → `out_insn = 0x00000013`, `out_pc = 0x1000`, `out_is_compressed = 0`; next request to `0x1004`.
- Word `0x40814501` at 0x1000 → outputs `0x00004501` @0x1000, then `0x00004081` @0x1002, both compressed, in consecutive cycles with `out_ready = 1`.
- Straddle: words `0x00134505` @0x1000 and `0x45010000` @0x1004 → `0x00004505` @0x1000, `0x00000013` @0x1002 (appears only after the second response), `0x00004501` @0x1006.
- Redirect to `0x2002` while the 0x1004 fetch is in WAIT:
  - stale response discarded, no output from it
  - then request `0x2000`; respond `0x12345678` → `out_insn = 0x00001234`, `out_pc = 0x2002`, compressed
- Redirect asserted in the same cycle as `mem_resp_valid` → response dropped; next request goes to the redirect word; no spurious `out_valid`.
- `out_ready = 0` for 10 cycles with 1-cycle memory → `count` never exceeds 3, no request while `count ≥ 2`, outputs stable. On release, instructions emerge in PC order with no loss or duplication.
